// File: rtl/alu_if.sv
// Operand/result bundle between the datapath controller and the ALU.
// The master drives op and both operands; the ALU drives back the
// registered result.
interface alu_if;
  logic [2:0]  op;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] Output;

  modport master (output op, output A, output B, input Output);
  modport slave  (input op, input A, input B, output Output);
endinterface

// File: rtl/alu.sv
// 16-bit registered ALU: eight operations selected by op, with the result
// registered one edge after the operands are sampled.
// Op 111 drives a Fibonacci LFSR (taps 16,14,13,11). The first 111 edge
// after any other op, or after reset, seeds the LFSR from A. Every
// following 111 edge advances it by one step.
module alu (
  input logic clk,
  input logic reset,
  alu_if.slave bus
);

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_CLAMP = 3'b101,
    OP_SHL   = 3'b110,
    OP_RNG   = 3'b111
  } op_t;

  op_t         op_sel;
  logic [15:0] lfsr;
  logic        rng_active;
  logic [15:0] result;
  logic [15:0] lfsr_next;
  logic        rng_active_next;
  logic [16:0] clamp_div;
  logic        feedback;
  logic [15:0] seed;

  assign op_sel = op_t'(bus.op);

  // Compute the result and the next RNG state for the operation presented
  // this cycle. The clamp divisor is formed in 17 bits so that B=0xFFFF
  // yields a divisor of 0x10000. It is never zero.
  always_comb begin
    result          = 16'h0000;
    lfsr_next       = lfsr;
    rng_active_next = 1'b0;
    clamp_div       = {1'b0, bus.B} + 17'd1;
    feedback        = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    seed            = (bus.A == 16'h0000) ? 16'hACE1 : bus.A;
    unique case (op_sel)
      OP_ADD:   result = bus.A + bus.B;
      OP_SUB:   result = bus.A - bus.B;
      OP_AND:   result = bus.A & bus.B;
      OP_OR:    result = bus.A | bus.B;
      OP_XOR:   result = bus.A ^ bus.B;
      OP_CLAMP: result = 16'({1'b0, bus.A} % clamp_div);
      OP_SHL:   result = bus.A << bus.B[3:0];
      OP_RNG: begin
        rng_active_next = 1'b1;
        if (!rng_active) begin
          lfsr_next = seed;
          result    = seed;
        end else begin
          lfsr_next = {lfsr[14:0], feedback};
          result    = {lfsr[14:0], feedback};
        end
      end
      default: result = 16'h0000;
    endcase
  end

  // Register the result and RNG state. Reset takes priority over every
  // op and forces the next 111 edge to be a seed cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.Output <= 16'h0000;
      lfsr       <= 16'hACE1;
      rng_active <= 1'b0;
    end else begin
      bus.Output <= result;
      lfsr       <= lfsr_next;
      rng_active <= rng_active_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases followed by randomized
// traffic, compared against a behavioural model of the ALU rules.
module tb_alu;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  // Reference model state
  logic [15:0] m_lfsr;
  bit          m_active;
  logic [15:0] m_out;

  alu_if bus ();

  alu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsrStep(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance the model by one clock edge using the ALU rules.
  task automatic modelEdge(input bit rst, input int op, input int a, input int b);
    if (rst) begin
      m_out    = 16'h0000;
      m_lfsr   = 16'hACE1;
      m_active = 0;
    end else begin
      case (op)
        0: m_out = 16'((a + b) % 65536);
        1: m_out = 16'((a - b + 65536) % 65536);
        2: m_out = 16'(a & b);
        3: m_out = 16'(a | b);
        4: m_out = 16'(a ^ b);
        5: m_out = 16'(a % (b + 1));
        6: m_out = 16'((a * (1 << (b % 16))) % 65536);
        default: begin
          if (!m_active) m_lfsr = (a == 0) ? 16'hACE1 : 16'(a);
          else           m_lfsr = lfsrStep(m_lfsr);
          m_out = m_lfsr;
        end
      endcase
      m_active = (op == 7);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare with the model.
  task automatic applyStimulus(input bit rst, input int op, input int a, input int b);
    @(negedge clk);
    reset  = rst;
    bus.op = 3'(op);
    bus.A  = 16'(a);
    bus.B  = 16'(b);
    @(posedge clk);
    #1;
    modelEdge(rst, op, a, b);
    checkOutput("model", bus.Output, m_out);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    m_lfsr   = 16'hACE1;
    m_active = 0;
    m_out    = 16'h0000;
    reset    = 1'b1;
    bus.op   = 3'd0;
    bus.A    = 16'h0;
    bus.B    = 16'h0;

    // Reset and seed substitution for A=0
    applyStimulus(1, 3, 16'h1234, 16'h5678);
    applyStimulus(1, 7, 16'hFFFF, 16'h0001);
    checkOutput("reset_out", bus.Output, 16'h0000);
    applyStimulus(0, 7, 0, 0);
    checkOutput("seed_zero", bus.Output, 16'hACE1);

    // Wrapping arithmetic
    applyStimulus(0, 0, 16'hF000, 16'hF003);
    checkOutput("add_wrap", bus.Output, 16'hE003);
    applyStimulus(0, 1, 16'h0001, 16'h0002);
    checkOutput("sub_wrap", bus.Output, 16'hFFFF);

    // RNG sequence; A changes during run cycles are ignored
    applyStimulus(0, 7, 12, 0);
    checkOutput("rng0", bus.Output, 16'd12);
    applyStimulus(0, 7, 16'h5555, 0);
    checkOutput("rng1", bus.Output, 16'd24);
    applyStimulus(0, 7, 0, 0);
    checkOutput("rng2", bus.Output, 16'd48);
    applyStimulus(0, 7, 16'hFFFF, 0);
    checkOutput("rng3", bus.Output, 16'd96);
    applyStimulus(0, 7, 12, 0);
    checkOutput("rng4", bus.Output, 16'd192);

    // Clamp, including both divisor extremes
    applyStimulus(0, 5, 192, 255);
    checkOutput("clamp_in", bus.Output, 16'd192);
    applyStimulus(0, 5, 1000, 255);
    checkOutput("clamp_fold", bus.Output, 16'd232);
    applyStimulus(0, 5, 7, 0);
    checkOutput("clamp_b0", bus.Output, 16'd0);
    applyStimulus(0, 5, 16'h1234, 16'hFFFF);
    checkOutput("clamp_bmax", bus.Output, 16'h1234);

    // Logic and shift
    applyStimulus(0, 2, 16'h0F0F, 16'h00FF);
    checkOutput("and", bus.Output, 16'h000F);
    applyStimulus(0, 3, 16'h0F0F, 16'h00FF);
    checkOutput("or", bus.Output, 16'h0FFF);
    applyStimulus(0, 4, 16'h0F0F, 16'h00FF);
    checkOutput("xor", bus.Output, 16'h0FF0);
    applyStimulus(0, 6, 16'h0001, 16'h0013);
    checkOutput("shl", bus.Output, 16'h0008);

    // Reseed after an intervening op, and reset priority over RNG
    applyStimulus(0, 7, 12, 0);
    applyStimulus(0, 7, 12, 0);
    checkOutput("rng_run", bus.Output, 16'd24);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 7, 5, 0);
    checkOutput("reseed", bus.Output, 16'd5);
    applyStimulus(1, 7, 9, 0);
    checkOutput("reset_prio", bus.Output, 16'h0000);
    applyStimulus(0, 7, 9, 0);
    checkOutput("seed_after_reset", bus.Output, 16'd9);
    applyStimulus(0, 7, 9, 0);
    checkOutput("step_after_seed", bus.Output, lfsrStep(16'd9));

    // Randomized traffic; ops biased so RNG runs get long enough to matter
    for (int i = 0; i < 600; i++) begin
      int  op;
      int  a;
      int  b;
      bit  rst;
      op  = ($urandom_range(0, 3) == 0) ? 7 : int'($urandom_range(0, 7));
      a   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 65535));
      case ($urandom_range(0, 7))
        0:       b = 0;
        1:       b = 65535;
        default: b = int'($urandom_range(0, 65535));
      endcase
      rst = ($urandom_range(0, 39) == 0);
      applyStimulus(rst, op, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
